// File: rtl/efuse_pkg.sv
// rtl/efuse_pkg.sv - shared types and constants for the efuse load sequencer
package efuse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } efuse_ctrl_state_e;

  localparam int EFUSE_DW          = 8;
  localparam int EFUSE_DATA_NUM    = 8;
  localparam int EFUSE_TIMEOUT_CYC = 255;
  localparam int EFUSE_MAX_RETRY   = 2;

  localparam logic [EFUSE_DW-1:0] EFUSE_END_MARKER = '1;

endpackage

// File: rtl/efuse_load_ctrl_if.sv
// rtl/efuse_load_ctrl_if.sv - load handshake between the sequencer and the efuse macro
interface efuse_load_ctrl_if #(
  parameter int DATA_NUM = 8,
  parameter int DW       = 8
);

  logic                   efuse_load_req;
  logic                   efuse_load_done;
  logic                   efuse_reg_update;
  logic [DATA_NUM*DW-1:0] efuse_reg_data;

  modport master (
    output efuse_load_req,
    input  efuse_load_done,
    input  efuse_reg_update,
    input  efuse_reg_data
  );

  modport slave (
    input  efuse_load_req,
    output efuse_load_done,
    output efuse_reg_update,
    output efuse_reg_data
  );

endinterface

// File: rtl/efuse_ctrl_timer.sv
// rtl/efuse_ctrl_timer.sv - saturating wait-cycle counter with terminal-count flag
module efuse_ctrl_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0] CNT_TC  = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt;

  // Saturates so a stalled enable can never wrap back below the terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_TC);

endmodule

// File: rtl/efuse_load_ctrl.sv
// rtl/efuse_load_ctrl.sv - efuse load sequencer with marker check and retry
// EFUSE_LOAD_CTRL_TIMEOUT_EN adds the WAIT timeout path; without it WAIT waits for done forever.
module efuse_load_ctrl
  import efuse_pkg::*;
#(
  parameter int DATA_NUM    = EFUSE_DATA_NUM,
  parameter int DW          = EFUSE_DW,
  parameter int TIMEOUT_CYC = EFUSE_TIMEOUT_CYC,
  parameter int MAX_RETRY   = EFUSE_MAX_RETRY
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  efuse_load_ctrl_if.master      efuse,
  output logic [DATA_NUM*DW-1:0] o_trim_data,
  output logic                   o_trim_vld,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [2:0]             o_retry_cnt
);

  localparam logic [DW-1:0] END_MARKER =
    (DW == EFUSE_DW) ? DW'(EFUSE_END_MARKER) : {DW{1'b1}};

  efuse_ctrl_state_e state;
  logic              load_req;
  logic              timeout;
  logic              retry_ok;
  logic              marker_ok;

  assign efuse.efuse_load_req = load_req;
  assign retry_ok  = (o_retry_cnt < 3'(MAX_RETRY));
  assign marker_ok = (o_trim_data[DATA_NUM*DW-1 -: DW] == END_MARKER);

`ifdef EFUSE_LOAD_CTRL_TIMEOUT_EN
  logic timer_tc;

  // Held clear outside WAIT, so every entry into WAIT starts from zero.
  efuse_ctrl_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (state != ST_WAIT),
    .en      ((state == ST_WAIT) && !efuse.efuse_load_done),
    .tc      (timer_tc)
  );

  assign timeout = (state == ST_WAIT) && !efuse.efuse_load_done && timer_tc;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      load_req    <= 1'b0;
      o_trim_data <= '0;
      o_trim_vld  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_retry_cnt <= 3'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_start) begin
            state       <= ST_WAIT;
            load_req    <= 1'b1;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_trim_vld  <= 1'b0;
            o_retry_cnt <= 3'd0;
          end
        end
        ST_WAIT: begin
          // A capture takes priority over a timeout landing on the same edge.
          if (efuse.efuse_load_done && efuse.efuse_reg_update) begin
            o_trim_data <= efuse.efuse_reg_data;
            load_req    <= 1'b0;
            state       <= ST_CHECK;
          end else if (timeout) begin
            load_req <= 1'b0;
            if (retry_ok) begin
              state <= ST_RELEASE;
            end else begin
              state  <= ST_ERR;
              o_err  <= 1'b1;
              o_busy <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          if (marker_ok) begin
            state      <= ST_DONE;
            o_done     <= 1'b1;
            o_trim_vld <= 1'b1;
            o_busy     <= 1'b0;
          end else if (retry_ok) begin
            state <= ST_RELEASE;
          end else begin
            state  <= ST_ERR;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // The macro must see req low long enough to drop done before re-requesting.
          if (!efuse.efuse_load_done) begin
            state       <= ST_WAIT;
            load_req    <= 1'b1;
            o_retry_cnt <= o_retry_cnt + 3'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          load_req <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_load_ctrl.sv
// tb/tb_efuse_load_ctrl.sv - directed vector bench for efuse_load_ctrl
module tb_efuse_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [63:0] o_trim_data;
  logic        o_trim_vld;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [2:0]  o_retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  efuse_load_ctrl_if #(.DATA_NUM(8), .DW(8)) bus ();

  efuse_load_ctrl #(
    .DATA_NUM    (8),
    .DW          (8),
    .TIMEOUT_CYC (8),
    .MAX_RETRY   (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .efuse       (bus.master),
    .o_trim_data (o_trim_data),
    .o_trim_vld  (o_trim_vld),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_retry_cnt (o_retry_cnt)
  );

  always #5 clk = ~clk;

  // Macro model: done/update follow req by one flop; data chosen by attempt number.
  logic        macro_en = 1'b0;
  logic        done_ff;
  logic        req_d = 1'b0;
  int          pulse_cnt = 0;
  int          pulse_base = 0;
  logic [63:0] att_data [3];

  function automatic int clamp_idx(input int v);
    if (v < 0) return 0;
    if (v > 2) return 2;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_ff <= 1'b0;
    else        done_ff <= macro_en && bus.efuse_load_req;
  end

  always @(posedge clk) begin
    req_d <= bus.efuse_load_req;
    if (bus.efuse_load_req && !req_d) pulse_cnt <= pulse_cnt + 1;
  end

  assign bus.efuse_load_done  = done_ff;
  assign bus.efuse_reg_update = done_ff;
  assign bus.efuse_reg_data   = att_data[clamp_idx(pulse_cnt - pulse_base - 1)];

  typedef struct {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] d2;
    logic        exp_done;
    logic        exp_err;
    logic        exp_vld;
    logic [2:0]  exp_retry;
    logic [63:0] exp_trim;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 200 && o_busy; c++) @(negedge clk);
    check({name, "_finish"}, o_busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    att_data[0] = v.d0;
    att_data[1] = v.d1;
    att_data[2] = v.d2;
    macro_en    = 1'b1;
    pulse_base  = pulse_cnt;
    pulse_start();
    wait_idle(name);
    check({name, "_done"},   o_done,      v.exp_done);
    check({name, "_err"},    o_err,       v.exp_err);
    check({name, "_vld"},    o_trim_vld,  v.exp_vld);
    check({name, "_retry"},  o_retry_cnt, v.exp_retry);
    check({name, "_trim"},   o_trim_data, v.exp_trim);
    check({name, "_pulses"}, 64'(pulse_cnt - pulse_base), 64'(v.exp_pulses));
  endtask

  initial begin
    int runs [8];
    int n_runs;
    int cur;
    int cnt;

    vecs[0] = '{64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000,
                1'b1, 1'b0, 1'b1, 3'd0, 64'hFF00_0000_0000_0000, 1};
    vecs[1] = '{64'h0012_3456_789A_BCDE, 64'hFF11_2233_4455_6677, 64'hFF11_2233_4455_6677,
                1'b1, 1'b0, 1'b1, 3'd1, 64'hFF11_2233_4455_6677, 2};
    vecs[2] = '{64'h7F00_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_FFFF_FFFF,
                1'b0, 1'b1, 1'b0, 3'd2, 64'h00FF_FFFF_FFFF_FFFF, 3};
    vecs[3] = '{64'hFE01_0000_0000_0000, 64'h0102_0304_0506_0708, 64'hFFA5_5AA5_5AA5_5AA5,
                1'b1, 1'b0, 1'b1, 3'd2, 64'hFFA5_5AA5_5AA5_5AA5, 3};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0,
                1'b1, 1'b0, 1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};

    rst_n       = 1'b0;
    i_start     = 1'b0;
    att_data[0] = 64'h0;
    att_data[1] = 64'h0;
    att_data[2] = 64'h0;
    repeat (3) @(negedge clk);
    check("rst_req",   bus.efuse_load_req, 1'b0);
    check("rst_busy",  o_busy,      1'b0);
    check("rst_done",  o_done,      1'b0);
    check("rst_err",   o_err,       1'b0);
    check("rst_vld",   o_trim_vld,  1'b0);
    check("rst_retry", o_retry_cnt, 3'd0);
    check("rst_trim",  o_trim_data, 64'h0);
    rst_n = 1'b1;

    // Exact latency of a clean load from IDLE.
    att_data[0] = 64'hFF00_0000_0000_0000;
    macro_en    = 1'b1;
    pulse_base  = pulse_cnt;
    pulse_start();
    check("t_e0_req",  bus.efuse_load_req, 1'b1);
    check("t_e0_busy", o_busy, 1'b1);
    @(negedge clk);
    check("t_e1_done", o_done, 1'b0);
    @(negedge clk);
    check("t_e2_req",  bus.efuse_load_req, 1'b0);
    check("t_e2_busy", o_busy, 1'b1);
    check("t_e2_done", o_done, 1'b0);
    @(negedge clk);
    check("t_e3_done",  o_done,      1'b1);
    check("t_e3_vld",   o_trim_vld,  1'b1);
    check("t_e3_busy",  o_busy,      1'b0);
    check("t_e3_trim",  o_trim_data, 64'hFF00_0000_0000_0000);
    check("t_e3_retry", o_retry_cnt, 3'd0);

    // Restart from DONE: o_done drops for three cycles.
    att_data[0] = 64'hFFC3_0000_0000_0001;
    pulse_base  = pulse_cnt;
    pulse_start();
    check("rs_req", bus.efuse_load_req, 1'b1);
    check("rs_vld", o_trim_vld, 1'b0);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done) break;
      cnt++;
    end
    check("rs_done_low_cycles", 64'(cnt), 64'd3);
    check("rs_trim", o_trim_data, 64'hFFC3_0000_0000_0001);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // i_start held through WAIT/CHECK/RELEASE/WAIT must not restart the sequence.
    att_data[0] = 64'h00AA_0000_0000_0000;
    att_data[1] = 64'hFF55_0000_0000_0000;
    att_data[2] = 64'hFF55_0000_0000_0000;
    pulse_base  = pulse_cnt;
    @(negedge clk) i_start = 1'b1;
    repeat (7) @(negedge clk);
    i_start = 1'b0;
    wait_idle("ign");
    check("ign_done",   o_done,      1'b1);
    check("ign_retry",  o_retry_cnt, 3'd1);
    check("ign_pulses", 64'(pulse_cnt - pulse_base), 64'd2);
    check("ign_trim",   o_trim_data, 64'hFF55_0000_0000_0000);

    // Asynchronous reset while waiting for the macro.
    macro_en = 1'b0;
    pulse_start();
    repeat (2) @(negedge clk);
    check("ar_pre_req", bus.efuse_load_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req",   bus.efuse_load_req, 1'b0);
    check("ar_busy",  o_busy,      1'b0);
    check("ar_done",  o_done,      1'b0);
    check("ar_err",   o_err,       1'b0);
    check("ar_vld",   o_trim_vld,  1'b0);
    check("ar_retry", o_retry_cnt, 3'd0);
    check("ar_trim",  o_trim_data, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    run_vec(vecs[0], "ar_after");

    // Macro never answers.
    macro_en = 1'b0;
    n_runs   = 0;
    cur      = 0;
    pulse_start();
`ifdef EFUSE_LOAD_CTRL_TIMEOUT_EN
    for (int c = 0; c < 200; c++) begin
      if (bus.efuse_load_req) begin
        cur++;
      end else if (cur > 0) begin
        if (n_runs < 8) runs[n_runs] = cur;
        n_runs++;
        cur = 0;
      end
      if (!o_busy) break;
      @(negedge clk);
    end
    check("to_runs", 64'(n_runs), 64'd3);
    for (int r = 0; r < 3; r++) begin
      check($sformatf("to_width%0d", r), 64'(runs[r]), 64'd8);
    end
    check("to_err",   o_err,       1'b1);
    check("to_busy",  o_busy,      1'b0);
    check("to_vld",   o_trim_vld,  1'b0);
    check("to_retry", o_retry_cnt, 3'd2);
`else
    for (int c = 0; c < 60; c++) begin
      if (bus.efuse_load_req && o_busy) cur++;
      @(negedge clk);
    end
    check("nto_req_cycles", 64'(cur), 64'd60);
    check("nto_req",   bus.efuse_load_req, 1'b1);
    check("nto_busy",  o_busy,      1'b1);
    check("nto_err",   o_err,       1'b0);
    check("nto_retry", o_retry_cnt, 3'd0);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
